// File: rtl/edge_detect_mc_if.sv
// -----------------------------------------------------------------------------
// edge_detect_mc_if
// Signal bundle for the multi-channel synchronising edge detector.
//   din   : CH asynchronous inputs (no timing relation to clk)
//   mode  : 2 bits per channel, [2i+1:2i] = 00 off, 01 rise, 10 fall, 11 both
//   clr   : per-channel sticky flag clear (level)
//   dout  : filtered, synchronised level
//   pulse : one-cycle pulse on an accepted edge matching mode
//   flag  : sticky event flags
//   irq   : OR of all flag bits
// master = the side that drives inputs and observes results,
// slave  = the detector itself.
// -----------------------------------------------------------------------------
interface edge_detect_mc_if #(
   parameter int CH = 4
);
   logic [CH-1:0]   din;
   logic [2*CH-1:0] mode;
   logic [CH-1:0]   clr;
   logic [CH-1:0]   dout;
   logic [CH-1:0]   pulse;
   logic [CH-1:0]   flag;
   logic            irq;

   modport master (
      output din, mode, clr,
      input  dout, pulse, flag, irq
   );

   modport slave (
      input  din, mode, clr,
      output dout, pulse, flag, irq
   );
endinterface

// File: rtl/edge_detect_mc.sv
// -----------------------------------------------------------------------------
// edge_detect_mc
// Multi-channel synchronising edge detector. Each of CH asynchronous inputs
// passes through a SYNC_STAGES flop chain, then a stability filter that only
// accepts a new level after it persisted FILT_LEN consecutive cycles. An
// accepted edge produces a one-cycle pulse (if enabled by mode) and sets a
// sticky flag; irq is the OR of all flags.
// Ports:
//   clk : single clock, all logic on rising edge
//   rst : synchronous reset, active-high
//   bus : edge_detect_mc_if.slave (din, mode, clr in; dout, pulse, flag, irq out)
// -----------------------------------------------------------------------------
module edge_detect_mc #(
   parameter int            CH          = 4,
   parameter int            SYNC_STAGES = 2,
   parameter int            FILT_LEN    = 3,
   parameter logic [CH-1:0] INIT        = '0
) (
   input  logic             clk,
   input  logic             rst,
   edge_detect_mc_if.slave  bus
);

   localparam int            CW   = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

   // Mode decode: does an accepted edge of the given direction pulse?
   function automatic logic mode_hit(input logic [1:0] m, input logic rise);
      logic hit;
      case (m)
         2'b01:   hit = rise;
         2'b10:   hit = ~rise;
         2'b11:   hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
   logic [CH-1:0]                  syn;
   logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [CH-1:0]                  dout_q, dout_d;
   logic [CH-1:0]                  pulse_q, pulse_d;
   logic [CH-1:0]                  flag_q, flag_d;

   assign syn = sync_q[SYNC_STAGES-1];

   // Stage: filter / edge acceptance
   always_comb begin
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      pulse_d = '0;
      for (int i = 0; i < CH; i++) begin
         if (syn[i] == dout_q[i]) begin
            // A return to the accepted level discards any partial count.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == LAST) begin
            dout_d[i]  = syn[i];
            cnt_d[i]   = '0;
            pulse_d[i] = mode_hit(bus.mode[2*i +: 2], syn[i]);
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      // Set wins over clear when both happen in the same cycle.
      flag_d = (flag_q & ~bus.clr) | pulse_d;
   end

   // Stage: registers (sync chain, filtered level, pulse, flag)
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= {SYNC_STAGES{INIT}};
         dout_q  <= INIT;
         cnt_q   <= '0;
         pulse_q <= '0;
         flag_q  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.din};
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         flag_q  <= flag_d;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.pulse = pulse_q;
   assign bus.flag  = flag_q;
   assign bus.irq   = |flag_q;

endmodule

// File: doc/edge_detect_mc.md
# edge_detect_mc

Multi-channel synchronising edge detector: the next generation of the single-bit `edge_sync` block. It brings CH asynchronous inputs into the `clk` domain through a SYNC_STAGES flop chain and rejects glitches with a per-channel stability filter. Per channel it then produces a one-cycle edge pulse for a selectable edge type (rise/fall/both/off), plus a sticky event flag with clear. It sits at the boundary between external/slow-domain status lines and control logic in the `clk` domain, and drives an aggregated interrupt.

## Interface
- CH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: synchroniser depth (>=2).
- FILT_LEN, 3: consecutive cycles a new value must persist before it is accepted (>=1; 1 = no filtering beyond sync).
- INIT, {CH{1'b0}}: reset value of the synchroniser chain and filtered level, per channel.

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- din  in  CH  asynchronous inputs; no timing relation to `clk`.
- mode  in  2*CH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- clr  in  CH  per-channel flag clear; level, sampled each cycle.
- dout  out  CH  filtered, synchronised level.
- pulse  out  CH  one-cycle pulse on an accepted edge matching mode.
- flag  out  CH  sticky event flag.
- irq  out  1  OR of all `flag` bits (combinational from registered flags).

## Operation
- Reset (rst=1 at a rising edge): sync chain = INIT, dout = INIT, filter counters = 0, pulse = 0, flag = 0, so irq = 0. No edge is reported on reset release, whatever the din value. A reset mid-filter discards the partial count.
- Synchroniser: per channel, s[0] <= din[i], s[k] <= s[k-1]. The synchronised value is syn = s[SYNC_STAGES-1]. Only syn feeds later logic; din is never used elsewhere.
- Filter: per channel, counter cnt of width clog2(FILT_LEN+1).
  - syn == dout: cnt <= 0.
  - syn != dout and cnt == FILT_LEN-1: dout <= syn, cnt <= 0, an accepted edge occurs (rise if syn=1, fall if syn=0).
  - syn != dout otherwise: cnt <= cnt+1.
  - A return of syn to dout before acceptance clears cnt. No edge occurs and dout is unchanged.
- Pulse: registered. pulse[i] <= accepted edge AND mode match (01 with rise, 10 with fall, 11 with either). It is otherwise 0, so pulse is high for exactly one cycle, on the same edge that dout changes.
- Mode: sampled on the cycle of acceptance only. With mode 00, dout still tracks but no pulse is generated and no flag is set. Changing mode never creates a pulse by itself.
- Flag: flag[i] <= (flag[i] & ~clr[i]) | pulse_next[i]. Set and clear in the same cycle leaves the flag set (set wins). Clear of an already-clear flag has no effect.
- Channels are fully independent, and simultaneous edges on several channels are all reported in the same cycle.

## Timing
- Latency from the clk edge that first captures a new din value into s[0] to dout/pulse update: SYNC_STAGES + FILT_LEN - 1 cycles after that edge. The update lands on edge number SYNC_STAGES + FILT_LEN counting the capture edge as 1; defaults give edge 5.
- Input sampling uncertainty: +1 cycle, inherent to the async input.
- Minimum accepted pulse width at din: FILT_LEN clk periods. Shorter pulses must not change dout.
- Maximum edge rate: one accepted edge per FILT_LEN cycles per channel. Toggling faster than that is suppressed, not queued.
- flag rises on the same edge as pulse, and irq follows in the same cycle. clr takes effect on the next edge.

## Test plan
- Reset: set din=4'hF during rst=1 with INIT=0, then release. After 5 cycles, dout=4'hF and pulse[3:0]=4'hF for one cycle with mode=all 11. Repeat with INIT=4'hF: no pulse, flag=0, irq=0.
- Latency/edge types: defaults, mode ch0=01, ch1=10, ch2=11, ch3=00. Drive din 0->1 on all channels, hold 10 cycles, then 1->0.
  - Rise: pulse=4'b0101 exactly on the 5th edge after capture.
  - Fall: pulse=4'b0110.
  - dout follows on all 4 channels, and ch3 never pulses or flags.
- Glitch rejection: on ch0, pulse din high for 2 cycles, then 3 cycles. The 2-cycle pulse gives no dout change and no pulse. The 3-cycle pulse gives one rise pulse and then one fall pulse (mode 11).
- Flag/clr: generate a ch1 pulse, giving flag[1]=1 and irq=1. Assert clr[1], giving flag[1]=0 next cycle and irq=0. Assert clr[1] on the same cycle as a new ch1 pulse: flag[1] stays 1.
- Parameter sweep: CH=1/8, SYNC_STAGES=2/3, FILT_LEN=1/4, with random din held for random 1–8 cycles.
  - A scoreboard model predicts dout, pulse and flag each cycle.
  - Assert a zero mismatch count.
  - Assert pulse is never high two consecutive cycles on one channel.
- Reset mid-operation: assert rst for 1 cycle while ch0 cnt=2 (mid-filter). All outputs go to reset values next edge, and no pulse follows release.
